// File: rtl/mul_pipelined.sv
// mul_pipelined
// Four-stage pipelined 32x32 multiplier for the RV32IM multiply group.
// It handles MUL, MULH, MULHSU and MULHU.
//
// Operation of the datapath:
// - Operands are converted to unsigned magnitudes before stage 0.
// - Each stage adds the partial products for 8 bits of the multiplier.
// - The stage-3 register is then sign-corrected, and the requested half
//   of the product is selected.
// - The pipeline accepts one operation per cycle.
// - A high stall freezes every register.
//
// Ports:
//   clk       in   1   clock, rising edge
//   rst       in   1   synchronous active-high reset; takes priority over stall
//   stall     in   1   hold every pipeline register this cycle
//   i_valid   in   1   i_op/i_a/i_b carry a real operation
//   i_op      in   2   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   i_a       in  32   multiplicand (rs1)
//   i_b       in  32   multiplier (rs2)
//   o_valid   out  1   o_result holds a completed operation
//   o_result  out 32   selected product half; 0 whenever o_valid is 0
//
// Configuration macro:
//   MUL_OUTPUT_REG_EN
//   - Defined: o_valid/o_result are registered after the post-process.
//     Latency is then 5 cycles.
//   - Undefined: the outputs are driven combinationally from the stage-3
//     register. Latency is then 4 cycles.
module mul_pipelined (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        i_valid,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  output logic [31:0] o_result
);

  localparam int STAGES = 4;

  // Pre-process: magnitudes, product sign and half select.
  // MUL is treated as unsigned because the low half of the product does not
  // depend on signedness.
  logic        sign_a, sign_b, prod_neg, hi;
  logic [31:0] abs_a, abs_b;

  assign sign_a   = i_a[31] & ((i_op == 2'b01) | (i_op == 2'b10));
  assign sign_b   = i_b[31] & (i_op == 2'b01);
  // Negating 32'h8000_0000 returns 32'h8000_0000.
  // Read as unsigned, that is the correct magnitude.
  assign abs_a    = sign_a ? (~i_a + 32'd1) : i_a;
  assign abs_b    = sign_b ? (~i_b + 32'd1) : i_b;
  assign prod_neg = sign_a ^ sign_b;
  assign hi       = (i_op != 2'b00);

  // Pipeline registers.
  // The last stage needs no operand copies, because only its accumulator
  // feeds the post-process.
  logic [63:0]        acc_reg [STAGES];
  logic [31:0]        a_reg   [STAGES-1];
  logic [31:0]        b_reg   [STAGES-1];
  logic [STAGES-1:0]  neg_reg;
  logic [STAGES-1:0]  hi_reg;
  logic [STAGES-1:0]  valid_reg;

  // Per-stage inputs and next accumulator values.
  logic [63:0]        acc_in   [STAGES];
  logic [31:0]        a_in     [STAGES];
  logic [31:0]        b_in     [STAGES];
  logic [63:0]        acc_next [STAGES];

  // Adds the 8 partial products for multiplier bits base .. base+7.
  function automatic logic [63:0] stage_sum(
    input logic [63:0] acc,
    input logic [31:0] a,
    input logic [31:0] b,
    input int          base
  );
    logic [63:0] sum;
    sum = acc;
    for (int j = 0; j < 8; j++) begin
      if (b[base + j]) begin
        sum = sum + ({32'b0, a} << (base + j));
      end
    end
    return sum;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign acc_in[gi] = 64'd0;
        assign a_in[gi]   = abs_a;
        assign b_in[gi]   = abs_b;
      end else begin : g_rest
        assign acc_in[gi] = acc_reg[gi-1];
        assign a_in[gi]   = a_reg[gi-1];
        assign b_in[gi]   = b_reg[gi-1];
      end
      assign acc_next[gi] = stage_sum(acc_in[gi], a_in[gi], b_in[gi], 8 * gi);
    end
  endgenerate

  // Data fields load on every non-stalled cycle, whether or not the slot
  // is valid.
  // The valid chain is what marks a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_reg[k] <= '0;
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_reg[k] <= '0;
        b_reg[k] <= '0;
      end
      neg_reg   <= '0;
      hi_reg    <= '0;
      valid_reg <= '0;
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        acc_reg[k] <= acc_next[k];
      end
      for (int k = 0; k < STAGES - 1; k++) begin
        a_reg[k] <= a_in[k];
        b_reg[k] <= b_in[k];
      end
      neg_reg   <= {neg_reg[STAGES-2:0], prod_neg};
      hi_reg    <= {hi_reg[STAGES-2:0], hi};
      valid_reg <= {valid_reg[STAGES-2:0], i_valid};
    end
  end

  // Post-process: restore the sign, then pick the requested half.
  // The result is squashed to zero for an empty slot.
  logic [63:0] prod;
  logic [31:0] result_comb;
  logic        valid_comb;

  always_comb begin
    prod        = neg_reg[STAGES-1] ? (~acc_reg[STAGES-1] + 64'd1) : acc_reg[STAGES-1];
    valid_comb  = valid_reg[STAGES-1];
    result_comb = 32'h0;
    if (valid_comb) begin
      result_comb = hi_reg[STAGES-1] ? prod[63:32] : prod[31:0];
    end
  end

`ifdef MUL_OUTPUT_REG_EN
  logic        out_valid_reg;
  logic [31:0] out_result_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg  <= 1'b0;
      out_result_reg <= 32'h0;
    end else if (!stall) begin
      out_valid_reg  <= valid_comb;
      out_result_reg <= result_comb;
    end
  end

  assign o_valid  = out_valid_reg;
  assign o_result = out_result_reg;
`else
  assign o_valid  = valid_comb;
  assign o_result = result_comb;
`endif

endmodule

// File: tb/tb_mul_pipelined.sv
// tb_mul_pipelined
// Self-checking bench for mul_pipelined.
//
// How the bench works:
// - A driver issues operations on the falling edge.
// - Each accepted operation pushes its expected result into a scoreboard
//   queue. The entry also records the index of the non-stalled edge that
//   sampled the operation.
// - A monitor checks the outputs one time unit after every rising edge.
//   - When o_valid is set, it pops the queue, then compares the result
//     and the latency.
//   - Otherwise it checks that the output is zero, or that the output
//     holds its value across a stall.
module tb_mul_pipelined;

`ifdef MUL_OUTPUT_REG_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        i_valid = 1'b0;
  logic [1:0]  i_op = 2'b00;
  logic [31:0] i_a = 32'h0;
  logic [31:0] i_b = 32'h0;
  logic        o_valid;
  logic [31:0] o_result;

  mul_pipelined dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .i_valid  (i_valid),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_valid  (o_valid),
    .o_result (o_result)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          edge_cnt = 0;
  logic [31:0] exp_q[$];
  int          iss_q[$];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model written from the instruction definitions.
  // It sign- or zero-extends both operands to 64 bits, multiplies, and
  // takes the requested half.
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ea, eb;
    logic [63:0] p;
    ea = (op == 2'b01 || op == 2'b10) ? longint'($signed(a)) : longint'({32'b0, a});
    eb = (op == 2'b01) ? longint'($signed(b)) : longint'({32'b0, b});
    p  = ea * eb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Drives one cycle of stimulus.
  // If the operation will be accepted, its expected result is queued.
  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input logic st);
    @(negedge clk);
    stall   = st;
    i_valid = v;
    i_op    = op;
    i_a     = a;
    i_b     = b;
    if (v && !st && !rst) begin
      exp_q.push_back(exp);
      iss_q.push_back(edge_cnt + 1);
    end
    $display("issue v=%0b op=%0d a=%08h b=%08h stall=%0b exp=%08h", v, op, a, b, st, exp);
  endtask

  task automatic op_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, op, a, b, model(op, a, b), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'b00, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  // Asserts reset for one cycle, with stall also high.
  // Everything in flight is discarded, so the scoreboard is flushed too.
  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    stall   = 1'b1;
    i_valid = 1'b0;
    exp_q.delete();
    iss_q.delete();
    $display("reset asserted with stall");
    @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
  endtask

  // Monitor
  logic        prev_valid;
  logic [31:0] prev_result;

  always @(posedge clk) begin
    bit s, r;
    s = stall;
    r = rst;
    if (!s && !r) edge_cnt++;
    #1;
    if (r) begin
      chk(o_valid == 1'b0, "reset_valid", {31'b0, o_valid}, 32'h0);
      chk(o_result == 32'h0, "reset_result", o_result, 32'h0);
    end else if (s) begin
      chk(o_valid == prev_valid, "stall_hold_valid", {31'b0, o_valid}, {31'b0, prev_valid});
      chk(o_result == prev_result, "stall_hold_result", o_result, prev_result);
    end else if (o_valid) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "spurious_valid", o_result, 32'h0);
      end else begin
        logic [31:0] e;
        int iss;
        e   = exp_q.pop_front();
        iss = iss_q.pop_front();
        $display("result got=%08h exp=%08h", o_result, e);
        chk(o_result == e, "result", o_result, e);
        chk(edge_cnt - iss == LAT - 1, "latency", edge_cnt - iss + 1, LAT);
      end
    end else begin
      chk(o_result == 32'h0, "idle_result_zero", o_result, 32'h0);
      if (iss_q.size() > 0 && edge_cnt - iss_q[0] >= LAT - 1) begin
        chk(1'b0, "missing_valid", edge_cnt - iss_q[0] + 1, LAT);
        void'(exp_q.pop_front());
        void'(iss_q.pop_front());
      end
    end
    prev_valid  = o_valid;
    prev_result = o_result;
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Corner products of the four operations.
    drive(1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    idle(LAT + 1);
    drive(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    drive(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    drive(1'b1, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
    drive(1'b1, 2'b10, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
    drive(1'b1, 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    idle(LAT + 1);

    // Back-to-back operations with a bubble in the middle.
    drive(1'b1, 2'b00, 32'd3, 32'd5, 32'd15, 1'b0);
    drive(1'b1, 2'b11, 32'h8000_0000, 32'd4, 32'd2, 1'b0);
    drive(1'b1, 2'b01, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
    drive(1'b0, 2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 1'b0);
    drive(1'b1, 2'b00, 32'h0, $urandom, 32'h0, 1'b0);
    idle(LAT + 1);

    // Stall for three cycles while 6x7 is in flight.
    // The inputs driven during the stall must be ignored.
    drive(1'b1, 2'b00, 32'd6, 32'd7, 32'd42, 1'b0);
    idle(1);
    for (int i = 0; i < 3; i++) drive(1'b1, 2'b11, $urandom, $urandom, 32'h0, 1'b1);
    idle(LAT + 2);

    // Reset while the pipeline is full.
    op_model(2'b00, 32'd11, 32'd13);
    op_model(2'b01, $urandom, $urandom);
    op_model(2'b11, $urandom, $urandom);
    do_reset();
    idle(LAT + 3);

    // Randomized traffic with random stalls and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      logic [1:0]  op;
      int          sel;
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 7);
      a   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h0 : $urandom;
      sel = $urandom_range(0, 7);
      b   = (sel == 0) ? 32'h8000_0000 : (sel == 1) ? 32'hFFFF_FFFF : (sel == 2) ? 32'h1 : $urandom;
      if ($urandom_range(0, 99) < 2) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 8, op, a, b, model(op, a, b), $urandom_range(0, 99) < 15);
      end
    end
    idle(LAT + 4);

    chk(exp_q.size() == 0, "drain_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog: the stimulus above is finite, so this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_pipelined.md
# mul_pipelined

Four-stage pipelined 32×32 multiplier for the RV32IM M-extension multiply group (MUL, MULH, MULHSU, MULHU), the multiply counterpart to the team's pipelined divider in the EX stage. Operands are converted to magnitudes, a 64-bit product is accumulated 8 multiplier bits per stage, then sign-corrected and the requested half selected. It accepts one operation per cycle and freezes under the shared pipeline `stall`.

## Interface
- No parameters.
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high; clock clk
- stall  in  1  freeze every pipeline register (valid and data) this cycle
- i_valid  in  1  operands on i_a/i_b/i_op form a real operation
- i_op  in  2  00 MUL (low 32), 01 MULH (s×s high), 10 MULHSU (s×u high), 11 MULHU (u×u high)
- i_a  in  32  multiplicand (rs1)
- i_b  in  32  multiplier (rs2)
- o_valid  out  1  o_result holds a completed operation
- o_result  out  32  selected product half; forced 32'h0 when o_valid=0

## Operation
- Pre-process (combinational, before stage 1): sign_a = i_a[31] & (i_op==01 | i_op==10); sign_b = i_b[31] & (i_op==01). MUL treated unsigned (low half identical). abs_a/abs_b = two's-complement negate when sign set; abs(32'h8000_0000) = 32'h8000_0000 read as unsigned.
- Product sign prod_neg = sign_a ^ sign_b; half select hi = (i_op != 00).
- Stage k (k=0..3, register index k): acc_out = acc_in + Σ_{j=0..7} (b_abs[8k+j] ? {32'b0,a_abs} << (8k+j) : 0), 64-bit, wraps modulo 2^64 (cannot overflow for 32×32 unsigned). Stage 0 acc_in = 0.
- Each stage register carries: acc[63:0], a_abs, b_abs, prod_neg, hi, valid. Data fields load every non-stalled cycle regardless of i_valid; valid field carries i_valid.
- Post-process (combinational from stage 3 register): p = prod_neg ? -acc : acc (64-bit); o_result = o_valid ? (hi ? p[63:32] : p[31:0]) : 0.
- rst: all stage registers, including valid, clear to 0 on the next rising edge; rst has priority over stall. o_valid=0, o_result=0 after reset.

## Timing
- Latency 4 cycles: i_valid sampled at edge N with stall low for N..N+3 → o_valid=1 and result during cycle after edge N+3.
- Throughput 1 op/cycle; back-to-back valid inputs emerge back-to-back in order.
- stall high at an edge: no register changes; i_* ignored that cycle; o_valid/o_result hold. Each stalled edge adds one cycle of latency to every in-flight op.
- Bubbles (i_valid=0) propagate as o_valid=0 slots, o_result=0.
- rst mid-flight: all in-flight ops discarded; no o_valid pulse for them afterwards.
- No combinational path from i_* to o_*.

## Configuration
- `MUL_OUTPUT_REG_EN` defined: extra register after post-process captures o_valid and o_result (reset 0, obeys stall); latency 5 cycles, o_* purely registered.
- Not defined: post-process drives o_* combinationally from stage-3 register; latency 4 cycles.

## Test plan
- MUL a=32'hFFFF_FFFF b=32'hFFFF_FFFF → o_result 32'h0000_0001 after 4 cycles (5 with macro), o_valid one cycle.
- MULHU same operands → 32'hFFFF_FFFE; MULH same operands (−1×−1) → 32'h0000_0000; MULHSU same → 32'hFFFF_FFFF.
- MULH a=b=32'h8000_0000 → 32'h4000_0000; MULHSU a=32'h8000_0000 b=32'h0000_0002 → 32'hFFFF_FFFF; MUL a=7 b=−3 (32'hFFFF_FFFD) → 32'hFFFF_FFEB.
- Issue 4 back-to-back ops (MUL 3×5, MULHU 2^31×4, MULH −2×3, bubble, MUL 0×X) → results 15, 2, 32'hFFFF_FFFF, o_valid=0 with result 0, 0 on consecutive cycles.
- Issue MUL 6×7, assert stall for 3 cycles at cycle 2 → 42 appears exactly 3 cycles later than unstalled, o_* stable throughout stall.
- Fill pipeline with 3 valid ops, assert rst (with stall high) for one cycle → o_valid stays 0 for all following cycles until new issue; o_result 0.
